mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control unit that sequences the RV32I-subset datapath (register file, ALU, immediate generator, PC register). It fetches through a req/ready instruction-memory handshake, decodes `inst_field`, then drives `Branch`, `Jump`, `MemtoReg`, `ALUSrc_B`, `ImmSel`, `ALU_Control` and `RegWrite`, plus the PC/IR enables, once per state. It sits between the memory interfaces and the datapath and replaces the hard-wired `CE=1` on the PC with a controlled `PC_CE`.

## Interface
Parameters:
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `inst_field`  in  32  instruction word; stable while `IR_write` is low.
- `imem_ready`  in  1  instruction memory has a valid word this cycle.
- `dmem_ready`  in  1  data access completes this cycle.
- `imem_req`  out  1  fetch request.
- `IR_write`  out  1  latch `inst_field` into the IR.
- `PC_CE`  out  1  PC register enable.
- `dmem_req`  out  1  data access request.
- `MemRW`  out  1  1 = store, 0 = load.
- `Branch`, `Jump`, `ALUSrc_B`, `RegWrite`  out  1 each  datapath controls.
- `MemtoReg`  out  2  writeback select: 00 ALU, 01 memory, 10 PC+4.
- `ImmSel`  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- `ALU_Control`  out  3  000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 SRL, 110 SUB, 111 SLT.
- `illegal`  out  1  sticky illegal-opcode flag.
- `state_o`  out  3  current state, for debug.
- `cycle_cnt`, `instret_cnt`  out  `CNT_W` each  performance counters.

## Operation
- States: `START`, `FETCH`, `DECODE`, `EXEC`, `MEM`, `WB`, `TRAP`.
- `START`: all outputs 0. Always moves to `FETCH` on the next cycle.
- `FETCH`: `imem_req` = 1. When `imem_ready` = 1, pulse `IR_write` and move to `DECODE`. Otherwise hold.
- `DECODE`: register the decoded control word from the IR opcode/funct3/funct7.
  - Supported: R-type 0110011 (add, sub, and, or, xor, slt, srl), I-ALU 0010011 (addi, andi, ori, xori, slti, srli), lw 0000011, sw 0100011, beq 1100011, jal 1101111.
  - Any other opcode → `TRAP`. All others → `EXEC`.
- `EXEC`: `ALU_Control`, `ALUSrc_B` and `ImmSel` are driven from the decoded word.
  - R/I-type → `WB`.
  - lw/sw → `MEM` (ADD with I/S immediate).
  - beq: SUB, `Branch` = 1, `PC_CE` = 1, ImmSel B → `FETCH`.
  - jal: `Jump` = 1, `MemtoReg` = 10, `RegWrite` = 1, `PC_CE` = 1, ImmSel J → `FETCH`.
- `MEM`: `dmem_req` = 1 and `MemRW` set. ALU controls are held. Wait for `dmem_ready`.
  - sw: `PC_CE` = 1 on the ready cycle → `FETCH`.
  - lw → `WB`.
- `WB`: `RegWrite` = 1 and `PC_CE` = 1 for one cycle. `MemtoReg` = 01 for lw, 00 otherwise. Controls are held from `EXEC`. → `FETCH`.
- `TRAP`: `illegal` = 1, all other outputs 0. Stays in `TRAP` until reset.
- Every datapath control not listed for a state is 0.

## Timing
- Reset (`rst` = 0): state = `START`, every output 0 including the counters, `illegal` cleared. Reset takes effect immediately, including in the middle of a memory handshake; a pending `imem_req` or `dmem_req` drops in that cycle.
- Outputs are Moore-type: decoded from the state register and the registered decode word. No combinational path from `imem_ready`/`dmem_ready` to outputs except `IR_write` and `PC_CE` in the ready cycle.
- Minimum latency with 1-cycle memories:
  - beq, jal: 3 cycles (FETCH, DECODE, EXEC).
  - R/I-type, sw: 4 cycles.
  - lw: 5 cycles.
- Each additional wait cycle on a ready signal adds one cycle. `PC_CE` is asserted exactly once per retired instruction.
- The `RegWrite` and `PC_CE` edges coincide. The datapath samples PC+4 before the PC updates.

## Configuration
- `MC_CTRL_PERF_CNT_EN` defined:
  - `cycle_cnt` increments on every cycle outside `START`/`TRAP`.
  - `instret_cnt` increments on every cycle where `PC_CE` = 1.
  - Both wrap modulo 2^`CNT_W`.
- Not defined: both counter ports are tied to 0 and no counter flops are built.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the state enum;
  - opcode constants;
  - the ALU_Control, ImmSel and MemtoReg encodings;
  - the packed decoded-control-word struct.
- Sub-module `mc_decode`: purely combinational, maps opcode/funct3/funct7 to the control word plus a `valid` bit. `mc_ctrl` registers its output in `DECODE`.

## Test plan
- `add x3,x1,x2` (0x002081B3) with `imem_ready` always 1 → states FETCH, DECODE, EXEC, WB. In WB: `ALU_Control` = 010, `RegWrite` = 1, `PC_CE` = 1, `MemtoReg` = 00; `instret_cnt` = 1.
- `lw x5,8(x1)` with `dmem_ready` delayed 3 cycles → `dmem_req` high for 4 cycles with `MemRW` = 0. Then WB with `MemtoReg` = 01. Total 8 cycles.
- `beq` (opcode 1100011) → EXEC has `ALU_Control` = 110, `Branch` = 1, `ImmSel` = 10, `PC_CE` = 1; back in `FETCH` on cycle 4.
- `jal x1,16` → EXEC has `Jump` = 1, `RegWrite` = 1, `MemtoReg` = 10, `ImmSel` = 11. `sw` → MEM has `MemRW` = 1, `RegWrite` = 0.
- Opcode 0x7F → `TRAP`, `illegal` = 1 held for 10 cycles, `cycle_cnt` frozen. Asserting `rst` = 0 clears everything asynchronously.
- `rst` asserted while in `MEM` with `dmem_req` = 1 → `dmem_req` drops in the same cycle. After release: `START`, then `FETCH` with `imem_req` = 1 one cycle later.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types for the multi-cycle control unit.
// Holds the state enum, RV32I opcode constants, the ALU/immediate/writeback
// encodings and the packed decoded-control-word struct.
package mc_ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned OPC_W   = 7;

  typedef enum logic [STATE_W-1:0] {
    ST_START  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  localparam logic [OPC_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_IALU   = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b011,
    ALU_NOR = 3'b100,
    ALU_SRL = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } mem_to_reg_e;

  typedef struct packed {
    alu_ctrl_e alu_ctrl;
    logic      alu_src_b;
    imm_sel_e  imm_sel;
    logic      is_load;
    logic      is_store;
    logic      is_branch;
    logic      is_jal;
  } ctrl_word_t;

  // funct3 -> ALU operation for the register/immediate ALU groups
  function automatic alu_ctrl_e alu_from_funct3(input logic [2:0] funct3,
                                                input logic       is_sub);
    case (funct3)
      3'b000:  alu_from_funct3 = is_sub ? ALU_SUB : ALU_ADD;
      3'b111:  alu_from_funct3 = ALU_AND;
      3'b110:  alu_from_funct3 = ALU_OR;
      3'b100:  alu_from_funct3 = ALU_XOR;
      3'b010:  alu_from_funct3 = ALU_SLT;
      3'b101:  alu_from_funct3 = ALU_SRL;
      default: alu_from_funct3 = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational instruction decoder.
// Ports: opcode_i/funct3_i/funct7_i instruction fields in; cw_c decoded
// control word and valid_c (supported opcode) out.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  output ctrl_word_t  cw_c,
  output logic        valid_c
);

  // Control word per opcode group; unsupported opcodes clear valid_c
  always_comb begin
    cw_c           = '0;
    cw_c.alu_ctrl  = ALU_ADD;
    cw_c.imm_sel   = IMM_I;
    valid_c        = 1'b1;
    case (opcode_i)
      OP_RTYPE: begin
        cw_c.alu_ctrl = alu_from_funct3(funct3_i, funct7_i == 7'b0100000);
      end
      OP_IALU: begin
        cw_c.alu_ctrl  = alu_from_funct3(funct3_i, 1'b0);
        cw_c.alu_src_b = 1'b1;
      end
      OP_LOAD: begin
        cw_c.alu_src_b = 1'b1;
        cw_c.is_load   = 1'b1;
      end
      OP_STORE: begin
        cw_c.alu_src_b = 1'b1;
        cw_c.imm_sel   = IMM_S;
        cw_c.is_store  = 1'b1;
      end
      OP_BRANCH: begin
        cw_c.alu_ctrl  = ALU_SUB;
        cw_c.imm_sel   = IMM_B;
        cw_c.is_branch = 1'b1;
      end
      OP_JAL: begin
        cw_c.imm_sel = IMM_J;
        cw_c.is_jal  = 1'b1;
      end
      default: valid_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control unit for the RV32I-subset datapath.
// Ports: clk, rst (async active-low); inst_field, imem_ready, dmem_ready in;
// imem_req/IR_write fetch handshake, dmem_req/MemRW data handshake,
// PC_CE, Branch, Jump, ALUSrc_B, RegWrite, MemtoReg, ImmSel, ALU_Control
// datapath controls, illegal flag, state_o debug, cycle_cnt/instret_cnt.
// Build option: MC_CTRL_PERF_CNT_EN enables the performance counters;
// otherwise both counter ports are tied to zero.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_field,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             IR_write,
  output logic             PC_CE,
  output logic             dmem_req,
  output logic             MemRW,
  output logic             Branch,
  output logic             Jump,
  output logic             ALUSrc_B,
  output logic             RegWrite,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       ImmSel,
  output logic [2:0]       ALU_Control,
  output logic             illegal,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_e     state_q, state_d;
  ctrl_word_t cw_q, cw_d;
  ctrl_word_t dec_cw;
  logic       dec_valid;

  // Operand/destination fields are consumed by the datapath, not here
  logic unused_inst_bits;
  assign unused_inst_bits = ^{inst_field[24:15], inst_field[11:7]};

  mc_decode u_decode (
    .opcode_i (inst_field[6:0]),
    .funct3_i (inst_field[14:12]),
    .funct7_i (inst_field[31:25]),
    .cw_c     (dec_cw),
    .valid_c  (dec_valid)
  );

  // State and decoded-word registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_START;
      cw_q    <= '0;
    end else begin
      state_q <= state_d;
      cw_q    <= cw_d;
    end
  end

  // Next state and Moore outputs; IR_write/PC_CE may follow ready in-cycle
  always_comb begin
    state_d     = state_q;
    cw_d        = cw_q;
    imem_req    = 1'b0;
    IR_write    = 1'b0;
    PC_CE       = 1'b0;
    dmem_req    = 1'b0;
    MemRW       = 1'b0;
    Branch      = 1'b0;
    Jump        = 1'b0;
    ALUSrc_B    = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = WB_ALU;
    ImmSel      = IMM_I;
    ALU_Control = ALU_AND;
    illegal     = 1'b0;
    case (state_q)
      ST_START: state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          IR_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        cw_d    = dec_cw;
        state_d = dec_valid ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        ALU_Control = cw_q.alu_ctrl;
        ALUSrc_B    = cw_q.alu_src_b;
        ImmSel      = cw_q.imm_sel;
        if (cw_q.is_branch) begin
          Branch  = 1'b1;
          PC_CE   = 1'b1;
          state_d = ST_FETCH;
        end else if (cw_q.is_jal) begin
          Jump     = 1'b1;
          MemtoReg = WB_PC4;
          RegWrite = 1'b1;
          PC_CE    = 1'b1;
          state_d  = ST_FETCH;
        end else if (cw_q.is_load || cw_q.is_store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        ALU_Control = cw_q.alu_ctrl;
        ALUSrc_B    = cw_q.alu_src_b;
        ImmSel      = cw_q.imm_sel;
        dmem_req    = 1'b1;
        MemRW       = cw_q.is_store;
        if (dmem_ready) begin
          // A store retires here; a load still needs its writeback cycle
          PC_CE   = cw_q.is_store;
          state_d = cw_q.is_store ? ST_FETCH : ST_WB;
        end
      end
      ST_WB: begin
        ALU_Control = cw_q.alu_ctrl;
        ALUSrc_B    = cw_q.alu_src_b;
        ImmSel      = cw_q.imm_sel;
        RegWrite    = 1'b1;
        PC_CE       = 1'b1;
        MemtoReg    = cw_q.is_load ? WB_MEM : WB_ALU;
        state_d     = ST_FETCH;
      end
      ST_TRAP: illegal = 1'b1;
      default: state_d = ST_START;
    endcase
  end

  assign state_o = state_q;

`ifdef MC_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;

  // Active cycles exclude START and TRAP; retirement is one PC_CE pulse
  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    if (state_q != ST_START && state_q != ST_TRAP)
      cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    if (PC_CE)
      instret_cnt_d = instret_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed per-cycle checks of mc_ctrl state, controls and
// counters against hand-derived expectations.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  localparam int unsigned CNT_W = 32;
`ifdef MC_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Bit positions within the packed observed-output vector
  localparam logic [16:0] M_IREQ = 17'h10000;
  localparam logic [16:0] M_IRW  = 17'h08000;
  localparam logic [16:0] M_PCCE = 17'h04000;
  localparam logic [16:0] M_DREQ = 17'h02000;
  localparam logic [16:0] M_MRW  = 17'h01000;
  localparam logic [16:0] M_BR   = 17'h00800;
  localparam logic [16:0] M_JMP  = 17'h00400;
  localparam logic [16:0] M_REGW = 17'h00100;
  localparam logic [16:0] M_WBM  = 17'h00040;
  localparam logic [16:0] M_WBPC = 17'h00080;
  localparam logic [16:0] M_ILL  = 17'h00001;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      inst_field;
  logic             imem_ready, dmem_ready;
  logic             imem_req, IR_write, PC_CE, dmem_req, MemRW;
  logic             Branch, Jump, ALUSrc_B, RegWrite, illegal;
  logic [1:0]       MemtoReg, ImmSel;
  logic [2:0]       ALU_Control, state_o;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  int unsigned      n_vec = 0;
  int unsigned      n_err = 0;
  logic [31:0]      exp_cyc = '0;
  logic [31:0]      exp_ret = '0;

  wire [16:0] obs = {imem_req, IR_write, PC_CE, dmem_req, MemRW, Branch, Jump,
                     ALUSrc_B, RegWrite, MemtoReg, ImmSel, ALU_Control, illegal};

  mc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_field  (inst_field),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .imem_req    (imem_req),
    .IR_write    (IR_write),
    .PC_CE       (PC_CE),
    .dmem_req    (dmem_req),
    .MemRW       (MemRW),
    .Branch      (Branch),
    .Jump        (Jump),
    .ALUSrc_B    (ALUSrc_B),
    .RegWrite    (RegWrite),
    .MemtoReg    (MemtoReg),
    .ImmSel      (ImmSel),
    .ALU_Control (ALU_Control),
    .illegal     (illegal),
    .state_o     (state_o),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [16:0] dp(input logic [2:0] alu, input logic srcb,
                                     input logic [1:0] imm);
    return (17'(srcb) << 9) | (17'(imm) << 4) | (17'(alu) << 1);
  endfunction

  function automatic logic [31:0] cnt_exp(input logic [31:0] v);
    return PERF ? v : 32'd0;
  endfunction

  // One clock cycle: drive readies, check at negedge, advance the count model
  task automatic cyc(input string tag, input logic [2:0] st, input logic [16:0] exp_o,
                     input logic ir, input logic dr);
    imem_ready = ir;
    dmem_ready = dr;
    @(negedge clk);
    check({tag, "/state"}, 64'(state_o), 64'(st));
    check({tag, "/outs"}, 64'(obs), 64'(exp_o));
    check({tag, "/cycle_cnt"}, 64'(cycle_cnt), 64'(cnt_exp(exp_cyc)));
    check({tag, "/instret_cnt"}, 64'(instret_cnt), 64'(cnt_exp(exp_ret)));
    if (st != ST_START && st != ST_TRAP) exp_cyc = exp_cyc + 32'd1;
    if ((exp_o & M_PCCE) != '0) exp_ret = exp_ret + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [31:0] inst, input int waits);
    inst_field = inst;
    for (int i = 0; i < waits; i++) cyc({tag, "/fwait"}, ST_FETCH, M_IREQ, 1'b0, 1'b0);
    cyc({tag, "/fetch"}, ST_FETCH, M_IREQ | M_IRW, 1'b1, 1'b0);
    cyc({tag, "/decode"}, ST_DECODE, '0, 1'b1, 1'b0);
  endtask

  task automatic run_alu(input string tag, input logic [31:0] inst,
                         input logic [2:0] alu, input logic srcb);
    fetch(tag, inst, 0);
    cyc({tag, "/exec"}, ST_EXEC, dp(alu, srcb, IMM_I), 1'b1, 1'b0);
    cyc({tag, "/wb"}, ST_WB, dp(alu, srcb, IMM_I) | M_REGW | M_PCCE, 1'b1, 1'b0);
  endtask

  task automatic run_lw(input string tag, input logic [31:0] inst, input int waits);
    fetch(tag, inst, 0);
    cyc({tag, "/exec"}, ST_EXEC, dp(ALU_ADD, 1'b1, IMM_I), 1'b1, 1'b0);
    for (int i = 0; i < waits; i++)
      cyc({tag, "/mwait"}, ST_MEM, dp(ALU_ADD, 1'b1, IMM_I) | M_DREQ, 1'b1, 1'b0);
    cyc({tag, "/mem"}, ST_MEM, dp(ALU_ADD, 1'b1, IMM_I) | M_DREQ, 1'b1, 1'b1);
    cyc({tag, "/wb"}, ST_WB, dp(ALU_ADD, 1'b1, IMM_I) | M_REGW | M_PCCE | M_WBM, 1'b1, 1'b0);
  endtask

  task automatic run_sw(input string tag, input logic [31:0] inst, input int fwaits,
                        input int waits);
    fetch(tag, inst, fwaits);
    cyc({tag, "/exec"}, ST_EXEC, dp(ALU_ADD, 1'b1, IMM_S), 1'b1, 1'b0);
    for (int i = 0; i < waits; i++)
      cyc({tag, "/mwait"}, ST_MEM, dp(ALU_ADD, 1'b1, IMM_S) | M_DREQ | M_MRW, 1'b1, 1'b0);
    cyc({tag, "/mem"}, ST_MEM, dp(ALU_ADD, 1'b1, IMM_S) | M_DREQ | M_MRW | M_PCCE, 1'b1, 1'b1);
  endtask

  initial begin
    rst        = 1'b0;
    inst_field = '0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", ST_START, '0, 1'b1, 1'b1);
    rst = 1'b1;
    cyc("start", ST_START, '0, 1'b1, 1'b0);

    run_alu("add", 32'h002081B3, ALU_ADD, 1'b0);
    run_alu("sub", 32'h402081B3, ALU_SUB, 1'b0);
    run_alu("slt", 32'h0020A1B3, ALU_SLT, 1'b0);
    run_alu("xori", 32'h0040C093, ALU_XOR, 1'b1);
    run_alu("srli", 32'h0020D093, ALU_SRL, 1'b1);
    run_alu("andi", 32'h0FF0F093, ALU_AND, 1'b1);
    run_lw("lw", 32'h0080A283, 3);
    run_sw("sw", 32'h0020A223, 2, 1);

    fetch("beq", 32'h00208463, 0);
    cyc("beq/exec", ST_EXEC, dp(ALU_SUB, 1'b0, IMM_B) | M_BR | M_PCCE, 1'b1, 1'b0);
    fetch("jal", 32'h010000EF, 0);
    cyc("jal/exec", ST_EXEC, dp(ALU_ADD, 1'b0, IMM_J) | M_JMP | M_REGW | M_PCCE | M_WBPC,
        1'b1, 1'b0);

    // Reset in the middle of a data handshake
    fetch("lwrst", 32'h0080A283, 0);
    cyc("lwrst/exec", ST_EXEC, dp(ALU_ADD, 1'b1, IMM_I), 1'b1, 1'b0);
    cyc("lwrst/mwait", ST_MEM, dp(ALU_ADD, 1'b1, IMM_I) | M_DREQ, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    check("memrst/dmem_req", 64'(dmem_req), 64'd0);
    check("memrst/state", 64'(state_o), 64'(ST_START));
    check("memrst/cycle_cnt", 64'(cycle_cnt), 64'd0);
    check("memrst/instret_cnt", 64'(instret_cnt), 64'd0);
    exp_cyc = '0;
    exp_ret = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc("memrst/start", ST_START, '0, 1'b0, 1'b0);
    cyc("memrst/fetch", ST_FETCH, M_IREQ, 1'b0, 1'b0);

    // Illegal opcode traps and holds
    fetch("ill", 32'h0000007F, 0);
    for (int i = 0; i < 10; i++) cyc("ill/trap", ST_TRAP, M_ILL, 1'b1, 1'b1);
    rst = 1'b0;
    #1;
    check("traprst/state", 64'(state_o), 64'(ST_START));
    check("traprst/illegal", 64'(illegal), 64'd0);
    check("traprst/cycle_cnt", 64'(cycle_cnt), 64'd0);
    check("traprst/instret_cnt", 64'(instret_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
